// File: rtl/multicycle_adder_chunk_adder.sv
// CHUNK-bit combinational ripple adder, shared across cycles by multicycle_adder.
// c_msb_in is the carry entering the top bit, used for signed-overflow detection.
module chunk_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    always_comb begin
        logic c;
        c        = ci;
        s        = '0;
        c_msb_in = ci;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb_in = c;
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/multicycle_adder.sv
// Multi-cycle add/subtract: WIDTH-bit operation processed CHUNK bits per clock,
// with valid/ready handshakes on both the request and result sides.
module multicycle_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NCHUNK - 1);

    if (CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $fatal(1, "multicycle_adder: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [CHUNK-1:0]   a_chunk;
    logic [CHUNK-1:0]   b_chunk;
    logic [CHUNK-1:0]   s_chunk;
    logic               c_out;
    logic               c_msb;
    logic               accept;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN);

    assign a_chunk = a_reg[idx*CHUNK +: CHUNK];
    assign b_chunk = b_reg[idx*CHUNK +: CHUNK];

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .x        (a_chunk),
        .y        (b_chunk),
        .ci       (carry),
        .s        (s_chunk),
        .cout     (c_out),
        .c_msb_in (c_msb)
    );

    // Operands are only meaningful while RUN, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_reg <= a;
            b_reg <= b ^ {WIDTH{sub}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state <= RUN;
                        idx   <= '0;
                        carry <= sub ? 1'b1 : cin;
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    sum[idx*CHUNK +: CHUNK] <= s_chunk;
                    carry <= c_out;
                    if (idx == LAST) begin
                        cout  <= c_out;
                        ovf   <= c_out ^ c_msb;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_adder.sv
// Bench for multicycle_adder: five parameter configurations checked every cycle
// against an arithmetic reference model, plus directed cases on the 32/8 instance.
module tb_multicycle_adder;

    localparam int NCFG = 5;
    localparam int WS[NCFG] = '{32, 8, 8, 16, 32};
    localparam int CS[NCFG] = '{8, 1, 8, 4, 32};

    logic        clk;
    logic        rst;
    logic        in_valid_v  [NCFG];
    logic        in_ready_v  [NCFG];
    logic [31:0] a_v         [NCFG];
    logic [31:0] b_v         [NCFG];
    logic        cin_v       [NCFG];
    logic        sub_v       [NCFG];
    logic        out_valid_v [NCFG];
    logic        out_ready_v [NCFG];
    logic [31:0] sum_v       [NCFG];
    logic        cout_v      [NCFG];
    logic        ovf_v       [NCFG];
    logic        busy_v      [NCFG];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int W = WS[g];
        localparam int C = CS[g];
        logic [W-1:0] a_l;
        logic [W-1:0] b_l;
        logic [W-1:0] sum_l;
        assign a_l = a_v[g][W-1:0];
        assign b_l = b_v[g][W-1:0];
        multicycle_adder #(.WIDTH(W), .CHUNK(C)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid_v[g]),
            .in_ready  (in_ready_v[g]),
            .a         (a_l),
            .b         (b_l),
            .cin       (cin_v[g]),
            .sub       (sub_v[g]),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready_v[g]),
            .sum       (sum_l),
            .cout      (cout_v[g]),
            .ovf       (ovf_v[g]),
            .busy      (busy_v[g])
        );
        assign sum_v[g] = 32'(sum_l);
    end

    // Reference arithmetic: returns {ovf, cout, sum} from integer math.
    function automatic logic [33:0] ref_op(input int w, input logic [31:0] a, input logic [31:0] b,
                                           input logic cin, input logic sub);
        longint mask, half, ua, ub, sa, sb, full, exact;
        logic   c, o;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        if (sub) full = ua + ((~ub) & mask) + 1;
        else     full = ua + ub + longint'(cin);
        c     = ((full >> w) & 1) != 0;
        sa    = (ua >= half) ? ua - (mask + 1) : ua;
        sb    = (ub >= half) ? ub - (mask + 1) : ub;
        exact = sub ? sa - sb : sa + sb + longint'(cin);
        o     = (exact < -half) || (exact > half - 1);
        return {o, c, 32'(full & mask)};
    endfunction

    function automatic logic [31:0] pick(input int w);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'((longint'(1) << w) - 1);
            2:       return 32'(longint'(1) << (w - 1));
            3:       return 32'((longint'(1) << (w - 1)) - 1);
            default: return $urandom;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: one pending operation per config with a cycle countdown.
    logic        m_run  [NCFG];
    logic        m_ov   [NCFG];
    int          m_rem  [NCFG];
    logic [31:0] m_sum  [NCFG];
    logic        m_cout [NCFG];
    logic        m_ovf  [NCFG];
    logic [31:0] p_sum  [NCFG];
    logic        p_cout [NCFG];
    logic        p_ovf  [NCFG];

    always @(posedge clk) begin
        for (int k = 0; k < NCFG; k++) begin
            if (rst) begin
                m_run[k]  <= 1'b0;
                m_ov[k]   <= 1'b0;
                m_rem[k]  <= 0;
                m_sum[k]  <= '0;
                m_cout[k] <= 1'b0;
                m_ovf[k]  <= 1'b0;
            end else if (m_run[k]) begin
                m_rem[k] <= m_rem[k] - 1;
                if (m_rem[k] == 1) begin
                    m_run[k]  <= 1'b0;
                    m_ov[k]   <= 1'b1;
                    m_sum[k]  <= p_sum[k];
                    m_cout[k] <= p_cout[k];
                    m_ovf[k]  <= p_ovf[k];
                end
            end else begin
                if (m_ov[k] && out_ready_v[k]) m_ov[k] <= 1'b0;
                if (in_valid_v[k] && (!m_ov[k] || out_ready_v[k])) begin
                    m_run[k] <= 1'b1;
                    m_rem[k] <= WS[k] / CS[k];
                    {p_ovf[k], p_cout[k], p_sum[k]} <=
                        ref_op(WS[k], a_v[k], b_v[k], cin_v[k], sub_v[k]);
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < NCFG; k++) begin
            if (rst) begin
                chk($sformatf("rst_out_valid[%0d]", k), 64'(out_valid_v[k]), 64'd0);
                chk($sformatf("rst_busy[%0d]", k), 64'(busy_v[k]), 64'd0);
                chk($sformatf("rst_in_ready[%0d]", k), 64'(in_ready_v[k]), 64'd1);
                chk($sformatf("rst_result[%0d]", k), {ovf_v[k], cout_v[k], sum_v[k]}, 64'd0);
            end else begin
                chk($sformatf("out_valid[%0d]", k), 64'(out_valid_v[k]), 64'(m_ov[k]));
                chk($sformatf("busy[%0d]", k), 64'(busy_v[k]), 64'(m_run[k]));
                chk($sformatf("in_ready[%0d]", k), 64'(in_ready_v[k]),
                    64'(!m_run[k] && (!m_ov[k] || out_ready_v[k])));
                if (m_ov[k])
                    chk($sformatf("result{ovf,cout,sum}[%0d]", k),
                        {ovf_v[k], cout_v[k], sum_v[k]}, {m_ovf[k], m_cout[k], m_sum[k]});
            end
        end
    end

    // Directed helpers for the 32/8 instance; each returns #1 after the relevant edge.
    task automatic start0(input logic [31:0] a, input logic [31:0] b, input logic cin, input logic sub);
        in_valid_v[0] = 1'b1;
        a_v[0] = a;
        b_v[0] = b;
        cin_v[0] = cin;
        sub_v[0] = sub;
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
    endtask

    task automatic wait_out0(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!out_valid_v[0] && lat < 50);
    endtask

    task automatic take0();
        out_ready_v[0] = 1'b1;
        @(posedge clk);
        #1;
        out_ready_v[0] = 1'b0;
    endtask

    task automatic drive_cfg(input int k);
        int waited;
        for (int op = 0; op < 500; op++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            in_valid_v[k] = 1'b1;
            a_v[k] = pick(WS[k]);
            b_v[k] = pick(WS[k]);
            cin_v[k] = 1'($urandom_range(0, 1));
            sub_v[k] = 1'($urandom_range(0, 1));
            waited = 0;
            forever begin
                @(negedge clk);
                if (in_ready_v[k]) break;
                waited++;
                if (waited > 200) break;
            end
            if (waited > 200) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout[%0d]: waited %0d cycles, expected under 200", k, waited);
            end
            @(posedge clk);
            #1;
            in_valid_v[k] = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        logic [33:0] held;
        bit         sweep_done;

        rst = 1'b1;
        for (int k = 0; k < NCFG; k++) begin
            in_valid_v[k] = 1'b0;
            out_ready_v[k] = 1'b0;
            a_v[k] = '0;
            b_v[k] = '0;
            cin_v[k] = 1'b0;
            sub_v[k] = 1'b0;
        end

        chk("pin_add_wrap", 64'(ref_op(32, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), {30'd0, 1'b0, 1'b1, 32'h0});
        chk("pin_add_ovf", 64'(ref_op(32, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)), {30'd0, 1'b1, 1'b0, 32'h8000_0000});
        chk("pin_sub8_ovf", 64'(ref_op(8, 32'h80, 32'h01, 1'b0, 1'b1)), {30'd0, 1'b1, 1'b1, 32'h7F});
        chk("pin_sub8_borrow", 64'(ref_op(8, 32'h00, 32'h01, 1'b1, 1'b1)), {30'd0, 1'b0, 1'b0, 32'hFF});

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Carry ripples through every chunk.
        start0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_out0(lat);
        chk("t1_latency", 64'(lat), 64'd4);
        chk("t1_result", {ovf_v[0], cout_v[0], sum_v[0]}, {1'b0, 1'b1, 32'h0});
        take0();
        chk("t1_taken", 64'(out_valid_v[0]), 64'd0);

        start0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0);
        wait_out0(lat);
        chk("t2_ovf_result", {ovf_v[0], cout_v[0], sum_v[0]}, {1'b1, 1'b0, 32'h8000_0000});
        take0();
        start0(32'd5, 32'd7, 1'b1, 1'b1);
        wait_out0(lat);
        chk("t2_sub_result", {ovf_v[0], cout_v[0], sum_v[0]}, {1'b0, 1'b0, 32'hFFFF_FFFE});
        take0();

        // Backpressure: result frozen and new requests ignored.
        start0(32'd100, 32'd23, 1'b1, 1'b0);
        wait_out0(lat);
        held = {ovf_v[0], cout_v[0], sum_v[0]};
        chk("t3_first", 64'(held), {1'b0, 1'b0, 32'd124});
        in_valid_v[0] = 1'b1;
        a_v[0] = 32'hDEAD_BEEF;
        b_v[0] = 32'h1234_5678;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_in_ready_low", 64'(in_ready_v[0]), 64'd0);
            chk("t3_held", {ovf_v[0], cout_v[0], sum_v[0]}, 64'd124);
        end
        @(posedge clk);
        #1;
        a_v[0] = 32'd1;
        b_v[0] = 32'd2;
        cin_v[0] = 1'b0;
        sub_v[0] = 1'b0;
        out_ready_v[0] = 1'b1;
        @(negedge clk);
        chk("t3_in_ready_with_out_ready", 64'(in_ready_v[0]), 64'd1);
        @(posedge clk);
        #1;
        in_valid_v[0] = 1'b0;
        out_ready_v[0] = 1'b0;
        chk("t3_handoff_busy", {out_valid_v[0], busy_v[0]}, 64'b01);
        wait_out0(lat);
        chk("t3_second_latency", 64'(lat), 64'd4);
        chk("t3_second_sum", 64'(sum_v[0]), 64'd3);
        take0();

        // Reset mid-operation discards the partial result.
        start0(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("t4_rst_out_valid", 64'(out_valid_v[0]), 64'd0);
        chk("t4_rst_sum", 64'(sum_v[0]), 64'd0);
        chk("t4_rst_in_ready", 64'(in_ready_v[0]), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        start0(32'd10, 32'd20, 1'b0, 1'b0);
        wait_out0(lat);
        chk("t4_after_rst_sum", 64'(sum_v[0]), 64'd30);
        take0();

        // Random sweep across all parameter configurations with random backpressure.
        sweep_done = 1'b0;
        fork
            begin
                fork
                    drive_cfg(1);
                    drive_cfg(2);
                    drive_cfg(3);
                    drive_cfg(4);
                join
                sweep_done = 1'b1;
            end
            begin
                while (!sweep_done) begin
                    @(posedge clk);
                    #1;
                    for (int k = 1; k < NCFG; k++) out_ready_v[k] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        for (int k = 0; k < NCFG; k++) out_ready_v[k] = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        for (int k = 0; k < NCFG; k++)
            chk($sformatf("drained[%0d]", k), {out_valid_v[k], busy_v[k]}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
